axis_rx_frame_fifo: RTL

// - Parametrised store-and-forward frame FIFO between Ethernet MAC RX (m_axis_rxd/m_axis_rxs) and the RDMA decapsulator.
// - Writes RX words into a DEPTH-word buffer and pairs each frame with its status word.
// - Commits good frames to the output. Rewinds and drops bad, overflowing or aborted frames.
// - Only whole, good frames reach s_axis_eth_* downstream.

---
 rtl/axis_rx_frame_fifo.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/axis_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO: buffers MAC RX words, commits good frames, rewinds bad or overflowing ones.
// Optional RX_FIFO_STATS_EN adds saturating good_frames / dropped_frames counters.
module axis_rx_frame_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int OK_BIT = 0
) (
  input  logic                            axis_clk,
  input  logic                            axis_rst,
  input  logic                            capture_en,
  input  logic [DATA_W-1:0]               s_axis_tdata,
  input  logic [DATA_W/8-1:0]             s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [31:0]                     s_axis_rxs_tdata,
  input  logic                            s_axis_rxs_tvalid,
  output logic                            s_axis_rxs_tready,
  output logic [DATA_W-1:0]               m_axis_eth_tdata,
  output logic [DATA_W/8-1:0]             m_axis_eth_tkeep,
  output logic                            m_axis_eth_tvalid,
  input  logic                            m_axis_eth_tready,
  output logic                            m_axis_eth_tlast,
  output logic                            frame_done,
  output logic                            frame_drop,
  output logic [15:0]                     frame_len_bytes,
  output logic [$clog2(DEPTH):0]          fill_words
`ifdef RX_FIFO_STATS_EN
  ,
  output logic [31:0]                     good_frames,
  output logic [31:0]                     dropped_frames
`endif
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ENT_W  = DATA_W + KEEP_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, RECV, DROP, WAIT_STS, WAIT_DROP_STS} state_t;

  state_t state, state_next;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] ram_q;
  logic             ram_valid;

  logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr;
  logic            full;

  logic        sts_q_valid;
  logic        sts_q_ok;
  logic [15:0] sts_q_len;
  logic        sts_unused;

  logic wr_en, commit_go, reject_go, overflow_go, rewind;
  logic out_ready, load_out, rd_issue;

  assign full       = (wr_ptr - rd_ptr) == FULL_CNT;
  assign fill_words = wr_ptr - rd_ptr;
  assign sts_unused = ^s_axis_rxs_tdata;
  assign s_axis_rxs_tready = !sts_q_valid;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (wr_en) state_next = s_axis_tlast ? WAIT_STS : RECV;
      RECV: begin
        if (wr_en && s_axis_tlast) state_next = WAIT_STS;
        else if (overflow_go)      state_next = DROP;
      end
      DROP:          if (s_axis_tvalid && s_axis_tlast) state_next = WAIT_DROP_STS;
      WAIT_STS:      if (sts_q_valid) state_next = IDLE;
      WAIT_DROP_STS: if (sts_q_valid) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  // RECV ignores capture_en so a frame that has started always completes.
  always_comb begin
    s_axis_tready = 1'b0;
    wr_en         = 1'b0;
    commit_go     = 1'b0;
    reject_go     = 1'b0;
    overflow_go   = 1'b0;
    rewind        = 1'b0;
    case (state)
      IDLE: begin
        s_axis_tready = capture_en && !full;
        wr_en         = s_axis_tvalid && capture_en && !full;
      end
      RECV: begin
        s_axis_tready = !full;
        wr_en         = s_axis_tvalid && !full;
        overflow_go   = s_axis_tvalid && full;
        rewind        = s_axis_tvalid && full;
      end
      DROP:          s_axis_tready = 1'b1;
      WAIT_STS: begin
        commit_go = sts_q_valid && sts_q_ok;
        reject_go = sts_q_valid && !sts_q_ok;
        rewind    = sts_q_valid && !sts_q_ok;
      end
      WAIT_DROP_STS: reject_go = sts_q_valid;
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      sts_q_valid <= 1'b0;
      sts_q_ok    <= 1'b0;
      sts_q_len   <= '0;
    end else if (commit_go || reject_go) begin
      sts_q_valid <= 1'b0;
    end else if (s_axis_rxs_tvalid && !sts_q_valid) begin
      sts_q_valid <= 1'b1;
      sts_q_ok    <= s_axis_rxs_tdata[OK_BIT];
      sts_q_len   <= s_axis_rxs_tdata[15:0];
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      frame_done      <= 1'b0;
      frame_drop      <= 1'b0;
      frame_len_bytes <= '0;
    end else begin
      if (rewind)     wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit_go) begin
        commit_ptr      <= wr_ptr;
        frame_len_bytes <= sts_q_len;
      end
      frame_done <= commit_go;
      frame_drop <= reject_go;
    end
  end

  // Two-stage read: RAM output register feeding the AXIS output register, so reads overlap stalls.
  assign out_ready = !m_axis_eth_tvalid || m_axis_eth_tready;
  assign load_out  = ram_valid && out_ready;
  assign rd_issue  = (rd_ptr != commit_ptr) && (!ram_valid || load_out);

  always_ff @(posedge axis_clk) begin
    if (wr_en)    mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (rd_issue) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      rd_ptr            <= '0;
      ram_valid         <= 1'b0;
      m_axis_eth_tvalid <= 1'b0;
      m_axis_eth_tdata  <= '0;
      m_axis_eth_tkeep  <= '0;
      m_axis_eth_tlast  <= 1'b0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      ram_valid <= rd_issue || (ram_valid && !load_out);
      if (load_out) begin
        m_axis_eth_tvalid <= 1'b1;
        m_axis_eth_tdata  <= ram_q[DATA_W-1:0];
        m_axis_eth_tkeep  <= ram_q[DATA_W+KEEP_W-1:DATA_W];
        m_axis_eth_tlast  <= ram_q[ENT_W-1];
      end else if (m_axis_eth_tready) begin
        m_axis_eth_tvalid <= 1'b0;
      end
    end
  end

`ifdef RX_FIFO_STATS_EN
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      good_frames    <= '0;
      dropped_frames <= '0;
    end else begin
      if (commit_go && good_frames != 32'hFFFF_FFFF)    good_frames    <= good_frames + 1'b1;
      if (reject_go && dropped_frames != 32'hFFFF_FFFF) dropped_frames <= dropped_frames + 1'b1;
    end
  end
`endif

endmodule
